// File: rtl/spim_seq_pkg.sv
// Shared constants and types for the SPI-master burst sequencer:
// register map, control bits, FSM states and bus-phase encoding.
package spim_seq_pkg;

  localparam logic [2:0] SPI_RX      = 3'd0;
  localparam logic [2:0] SPI_TX      = 3'd1;
  localparam logic [2:0] SPI_STATUS  = 3'd2;
  localparam logic [2:0] SPI_CONTROL = 3'd3;

  localparam int unsigned CTRL_SSO_BIT = 10;
  localparam logic [15:0] CTRL_SSO_ON  = 16'h0001 << CTRL_SSO_BIT;
  localparam logic [15:0] CTRL_SSO_OFF = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SSO_ON,
    ST_RUN,
    ST_SSO_OFF,
    ST_DONE
  } seq_state_t;

  // FREE is the idle/decision cycle; ACC1/ACC2 are the two held cycles.
  typedef enum logic [1:0] {
    PH_FREE,
    PH_ACC1,
    PH_ACC2
  } bus_phase_t;

  typedef struct packed {
    logic        rd;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_req_t;

endpackage

// File: rtl/spim_burst_sequencer_if.sv
// Register-port bus between the burst sequencer (master) and the SPI core (slave).
interface spim_burst_sequencer_if;
  logic        spi_select;
  logic        write_n;
  logic        read_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        readyfordata;
  logic        dataavailable;

  modport master (
    output spi_select, write_n, read_n, mem_addr, data_from_cpu,
    input  data_to_cpu, readyfordata, dataavailable
  );

  modport slave (
    input  spi_select, write_n, read_n, mem_addr, data_from_cpu,
    output data_to_cpu, readyfordata, dataavailable
  );
endinterface

// File: rtl/spim_seq_buf.sv
// Simple dual-port byte buffer: one write port, one registered read port.
module spim_seq_buf #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1 << AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spim_burst_sequencer.sv
// Autonomous N-byte full-duplex burst host for the SPI master register port.
// Optional bus-stall timeout enabled by defining SPIM_SEQ_TIMEOUT_EN.
module spim_burst_sequencer
  import spim_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 5
`ifdef SPIM_SEQ_TIMEOUT_EN
  , parameter int unsigned TO_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  error,
  input  logic                  tx_wr_en,
  input  logic [LEN_W-1:0]      tx_wr_addr,
  input  logic [7:0]            tx_wr_data,
  input  logic [LEN_W-1:0]      rx_rd_addr,
  output logic [7:0]            rx_rd_data,
  spim_burst_sequencer_if.master spi
);

  seq_state_t       state, state_n;
  bus_phase_t       phase;
  logic [LEN_W-1:0] len_q, tx_cnt, rx_cnt, in_flight;
  logic             accept, bus_free, launch, tx_inc, rx_cap, set_err, timeout;
  bus_req_t         req;
  logic [7:0]       tx_byte;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bus_free  = (phase == PH_FREE);
  assign in_flight = tx_cnt - rx_cnt;
  assign rx_cap    = (phase == PH_ACC2) && !spi.read_n;

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    req     = '{rd: 1'b0, addr: SPI_RX, data: '0};
    tx_inc  = 1'b0;
    set_err = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_n = (cmd_len == '0) ? ST_DONE : ST_SSO_ON;
      end
      ST_SSO_ON: begin
        if (bus_free) begin
          launch  = 1'b1;
          req     = '{rd: 1'b0, addr: SPI_CONTROL, data: CTRL_SSO_ON};
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        // Reads win so no more than two bytes are ever in the core.
        if (bus_free) begin
          if (rx_cnt == len_q) begin
            state_n = ST_SSO_OFF;
          end else if (timeout) begin
            set_err = 1'b1;
            state_n = ST_SSO_OFF;
          end else if (spi.dataavailable && (rx_cnt < tx_cnt)) begin
            launch = 1'b1;
            req    = '{rd: 1'b1, addr: SPI_RX, data: '0};
          end else if (spi.readyfordata && (tx_cnt < len_q) && (in_flight < LEN_W'(2))) begin
            launch = 1'b1;
            req    = '{rd: 1'b0, addr: SPI_TX, data: {8'h00, tx_byte}};
            tx_inc = 1'b1;
          end
        end
      end
      ST_SSO_OFF: begin
        if (bus_free) begin
          launch  = 1'b1;
          req     = '{rd: 1'b0, addr: SPI_CONTROL, data: CTRL_SSO_OFF};
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus_free) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        len_q  <= cmd_len;
        tx_cnt <= '0;
        rx_cnt <= '0;
      end else begin
        if (tx_inc) tx_cnt <= tx_cnt + 1'b1;
        if (rx_cap) rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase             <= PH_FREE;
      spi.spi_select    <= 1'b0;
      spi.write_n       <= 1'b1;
      spi.read_n        <= 1'b1;
      spi.mem_addr      <= '0;
      spi.data_from_cpu <= '0;
    end else begin
      case (phase)
        PH_FREE: begin
          if (launch) begin
            phase             <= PH_ACC1;
            spi.spi_select    <= 1'b1;
            spi.write_n       <= req.rd;
            spi.read_n        <= !req.rd;
            spi.mem_addr      <= req.addr;
            spi.data_from_cpu <= req.data;
          end
        end
        PH_ACC1: phase <= PH_ACC2;
        default: begin
          phase             <= PH_FREE;
          spi.spi_select    <= 1'b0;
          spi.write_n       <= 1'b1;
          spi.read_n        <= 1'b1;
          spi.mem_addr      <= '0;
          spi.data_from_cpu <= '0;
        end
      endcase
    end
  end

`ifdef SPIM_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      to_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (launch)        to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = &to_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)        error <= 1'b0;
    else if (accept)  error <= 1'b0;
    else if (set_err) error <= 1'b1;
  end

  spim_seq_buf #(.AW(LEN_W), .DW(8)) u_tx_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr_en),
    .wr_addr (tx_wr_addr),
    .wr_data (tx_wr_data),
    .rd_addr (tx_cnt),
    .rd_data (tx_byte)
  );

  spim_seq_buf #(.AW(LEN_W), .DW(8)) u_rx_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_cap),
    .wr_addr (rx_cnt),
    .wr_data (spi.data_to_cpu[7:0]),
    .rd_addr (rx_rd_addr),
    .rd_data (rx_rd_data)
  );

endmodule

// File: tb/tb_spim_burst_sequencer.sv
// Bench for spim_burst_sequencer: loopback SPI core model plus a burst-level reference model.
// Define SPIM_SEQ_TIMEOUT_EN to also exercise the timeout path (TO_W=6).
module tb_spim_burst_sequencer;

  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset, cmd_valid, cmd_ready, done, error, tx_wr_en;
  logic [LEN_W-1:0] cmd_len, tx_wr_addr, rx_rd_addr;
  logic [7:0]       tx_wr_data, rx_rd_data;

  always #5 clk = ~clk;

  spim_burst_sequencer_if spi ();

  spim_burst_sequencer #(
    .LEN_W(LEN_W)
`ifdef SPIM_SEQ_TIMEOUT_EN
    , .TO_W(6)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .done       (done),
    .error      (error),
    .tx_wr_en   (tx_wr_en),
    .tx_wr_addr (tx_wr_addr),
    .tx_wr_data (tx_wr_data),
    .rx_rd_addr (rx_rd_addr),
    .rx_rd_data (rx_rd_data),
    .spi        (spi)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SPI core model: TX holding register feeding a shifter, MISO looped to MOSI.
  logic       hold_full, shift_busy, rrdy, roe, sso, trdy_block, fin;
  logic [7:0] hold_byte, shift_byte, rxdata;
  int         shift_left, acc_len;

  assign spi.readyfordata  = !hold_full && !trdy_block;
  assign spi.dataavailable = rrdy;
  assign spi.data_to_cpu   = (spi.mem_addr == 3'd0) ? {8'h00, rxdata}
                           : {8'h00, rrdy, !hold_full, !shift_busy, 1'b0, roe, 3'b000};
  assign fin = spi.spi_select && (acc_len == 1);

  always @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0; shift_busy <= 1'b0; rrdy <= 1'b0; roe <= 1'b0; sso <= 1'b0;
      hold_byte <= '0; shift_byte <= '0; rxdata <= '0; shift_left <= 0; acc_len <= 0;
    end else begin
      acc_len <= spi.spi_select ? acc_len + 1 : 0;
      if (fin && !spi.read_n && spi.mem_addr == 3'd0) rrdy <= 1'b0;
      if (shift_busy) begin
        if (shift_left == 1) begin
          shift_busy <= 1'b0;
          rxdata     <= shift_byte;
          rrdy       <= 1'b1;
          if (rrdy && !(fin && !spi.read_n && spi.mem_addr == 3'd0)) roe <= 1'b1;
        end else begin
          shift_left <= shift_left - 1;
        end
      end else if (hold_full) begin
        shift_busy <= 1'b1;
        shift_byte <= hold_byte;
        hold_full  <= 1'b0;
        shift_left <= int'($urandom_range(20, 6));
      end
      if (fin && !spi.write_n && spi.mem_addr == 3'd1) begin
        hold_full <= 1'b1;
        hold_byte <= spi.data_from_cpu[7:0];
      end
      if (fin && !spi.write_n && spi.mem_addr == 3'd3) sso <= spi.data_from_cpu[10];
    end
  end

  // Burst-level reference model.
  logic [7:0]  tx_model [32];
  logic [7:0]  rx_model [32];
  logic        m_busy = 1'b0, m_to_mode = 1'b0;
  int          m_len = 0, m_stage = 0, m_sent = 0, m_got = 0;
  int          m_accepts = 0, m_done_cnt = 0, m_since = 0, sel_run = 0, sel_cycles = 0;
  logic [20:0] rec;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_busy = 1'b0; m_stage = 0; sel_run = 0;
    end else begin
      m_since++;
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
`ifndef SPIM_SEQ_TIMEOUT_EN
      chk("error_tied_low", 32'(error), 32'd0);
`endif
      if (spi.spi_select) begin
        sel_run++;
        sel_cycles++;
        chk("select_in_burst", 32'(m_busy && m_len != 0), 32'd1);
        chk("one_strobe", 32'(spi.write_n ^ spi.read_n), 32'd1);
        if (sel_run == 1) rec = {spi.mem_addr, spi.data_from_cpu, spi.write_n, spi.read_n};
        else chk("bus_hold", 32'({spi.mem_addr, spi.data_from_cpu, spi.write_n, spi.read_n}), 32'(rec));
        if (sel_run > 2) chk("bus_len_long", 32'(sel_run), 32'd2);
        if (sel_run == 2) begin
          if (!rec[1] && rec[20:18] == 3'd3) begin
            if (m_stage == 1) begin
              chk("sso_on_value", 32'(rec[17:2]), 32'h0400);
              m_stage = 2;
            end else begin
              chk("sso_off_value", 32'(rec[17:2]), 32'h0000);
              chk("sso_off_complete", 32'(m_got == m_len || m_to_mode), 32'd1);
              m_stage = 3;
            end
          end else if (!rec[1] && rec[20:18] == 3'd1) begin
            chk("tx_in_run", 32'(m_stage), 32'd2);
            chk("tx_byte", 32'(rec[17:2]), {24'h0, tx_model[m_sent]});
            chk("tx_window", 32'(m_sent < m_len && (m_sent - m_got) < 2), 32'd1);
            chk("sso_held", 32'(sso), 32'd1);
            m_sent++;
          end else if (!rec[0] && rec[20:18] == 3'd0) begin
            chk("rx_in_run", 32'(m_stage), 32'd2);
            chk("rx_order", 32'(m_got < m_sent), 32'd1);
            chk("no_roe", 32'(roe), 32'd0);
            m_got++;
          end else begin
            chk("bus_access_kind", 32'(rec[20:18]), 32'hFF);
          end
        end
      end else begin
        chk("idle_strobes", 32'({spi.write_n, spi.read_n}), 32'd3);
        if (sel_run != 0 && sel_run != 2) chk("bus_len_short", 32'(sel_run), 32'd2);
        sel_run = 0;
      end
      if (done) begin
        chk("done_while_busy", 32'(m_busy), 32'd1);
        if (m_len == 0) chk("zero_len_latency", 32'(m_since), 32'd1);
        else chk("done_after_sso_off", 32'(m_stage), 32'd3);
        for (int i = 0; i < m_got; i++) rx_model[i] = tx_model[i];
        m_busy = 1'b0;
        m_done_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        m_busy = 1'b1; m_len = int'(cmd_len); m_stage = 1;
        m_sent = 0; m_got = 0; m_since = 0; m_accepts++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input int a, input logic [7:0] d);
    tx_wr_en = 1'b1; tx_wr_addr = LEN_W'(a); tx_wr_data = d;
    tick();
    tx_wr_en = 1'b0;
    tx_model[a] = d;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 500 && !cmd_ready; k++) tick();
    chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic start(input int len);
    wait_ready();
    cmd_valid = 1'b1; cmd_len = LEN_W'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = m_done_cnt;
    for (int k = 0; k < budget && m_done_cnt == d0; k++) tick();
    chk("done_timeout", 32'(m_done_cnt != d0), 32'd1);
  endtask

  task automatic check_rx(input int n);
    for (int i = 0; i < n; i++) begin
      rx_rd_addr = LEN_W'(i);
      tick();
      chk("rx_buf", 32'(rx_rd_data), 32'(rx_model[i]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int d0, s0, a0, len;
    logic [7:0] lit [3];
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; tx_wr_en = 1'b0; tx_wr_addr = '0;
    tx_wr_data = '0; rx_rd_addr = '0; trdy_block = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_select", 32'(spi.spi_select), 32'd0);
    chk("rst_strobes", 32'({spi.write_n, spi.read_n}), 32'd3);
    chk("rst_addr_data", 32'({spi.mem_addr, spi.data_from_cpu}), 32'd0);
    chk("rst_rx_rd_data", 32'(rx_rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // three known bytes, echoed
    lit[0] = 8'hA5; lit[1] = 8'h3C; lit[2] = 8'h81;
    for (int i = 0; i < 3; i++) write_tx(i, lit[i]);
    d0 = m_done_cnt;
    start(3);
    wait_done(500);
    repeat (3) tick();
    chk("t1_done_once", 32'(m_done_cnt - d0), 32'd1);
    chk("t1_roe", 32'(roe), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rx_rd_addr = LEN_W'(i);
      tick();
      chk("t1_rx_literal", 32'(rx_rd_data), 32'(lit[i]));
    end
    check_rx(3);

    // zero-length command
    s0 = sel_cycles; d0 = m_done_cnt;
    start(0);
    wait_done(20);
    repeat (5) tick();
    chk("t2_no_select", 32'(sel_cycles - s0), 32'd0);
    chk("t2_done_once", 32'(m_done_cnt - d0), 32'd1);

    // maximum length, random data
    for (int i = 0; i < 31; i++) write_tx(i, 8'($urandom));
    start(31);
    wait_done(3000);
    chk("t3_all_received", 32'(m_got), 32'd31);
    check_rx(31);

    // random lengths
    repeat (4) begin
      len = int'($urandom_range(31, 1));
      for (int i = 0; i < len; i++) write_tx(i, 8'($urandom));
      start(len);
      wait_done(3000);
      check_rx(len);
    end

    // reset in the middle of a 4-byte burst
    for (int i = 0; i < 4; i++) write_tx(i, 8'($urandom));
    start(4);
    for (int k = 0; k < 1000 && m_sent < 2; k++) tick();
    chk("t4_reached_byte2", 32'(m_sent >= 2), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_select_idle", 32'(spi.spi_select), 32'd0);
    chk("t4_strobes_idle", 32'({spi.write_n, spi.read_n}), 32'd3);
    chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
    write_tx(0, 8'h5A); write_tx(1, 8'hC3);
    start(2);
    wait_done(500);
    check_rx(2);

    // cmd_valid held through a burst
    for (int i = 0; i < 3; i++) write_tx(i, 8'($urandom));
    wait_ready();
    a0 = m_accepts;
    cmd_valid = 1'b1; cmd_len = LEN_W'(3);
    wait_done(800);
    chk("t6_one_accept_during_run", 32'(m_accepts - a0), 32'd1);
    tick();
    cmd_valid = 1'b0;
    wait_done(800);
    chk("t6_two_bursts", 32'(m_accepts - a0), 32'd2);
    check_rx(3);

`ifdef SPIM_SEQ_TIMEOUT_EN
    // core never ready for data -> timeout, SSO released, done still pulses
    trdy_block = 1'b1; m_to_mode = 1'b1;
    write_tx(0, 8'h11); write_tx(1, 8'h22);
    start(2);
    wait_done(500);
    chk("t5_error", 32'(error), 32'd1);
    chk("t5_no_tx", 32'(m_sent), 32'd0);
    chk("t5_sso_off_written", 32'(m_stage), 32'd3);
    trdy_block = 1'b0; m_to_mode = 1'b0;
    start(2);
    chk("t5_error_cleared", 32'(error), 32'd0);
    wait_done(500);
    check_rx(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
